// File: rtl/pad_block_sequencer_if.sv
// Message-word input and rate-block output handshake of the SHA-3 front-end sequencer.
// The master drives message words and f_ack. The slave is the sequencer.
interface pad_block_sequencer_if #(parameter int RATE_WORDS = 18);
  logic [31:0]              in;
  logic                     in_ready;
  logic                     is_last;
  logic [1:0]               byte_num;
  logic                     buffer_full;
  logic [32*RATE_WORDS-1:0] out;
  logic                     out_ready;
  logic                     f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready
  );
endinterface

// File: rtl/pad_block_sequencer.sv
// Assembles 32-bit message words into rate blocks, applies SHA-3 padding (0x06..0x80),
// and holds each complete block until the permutation acknowledges it.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_ACCEPT | taking message words; a full block waits here for f_ack
// ST_PAD    | last word seen; fill remaining slots with zeros / final 0x80
// ST_DONE   | final padded block handed off; idle until reset
module pad_block_sequencer #(
  parameter int RATE_WORDS = 18
) (
  input logic clk,
  input logic reset,
  pad_block_sequencer_if.slave bus
);
  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam int BW = 32 * RATE_WORDS;

  typedef enum logic [1:0] {ST_ACCEPT, ST_PAD, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   block_q, block_d;
  logic            full, last_slot;
  logic            shift_en;
  logic [31:0]     shift_word;
  logic [31:0]     pad_word;

  assign full      = (count_q == CW'(RATE_WORDS));
  assign last_slot = (count_q == CW'(RATE_WORDS - 1));

  // Domain byte 0x06 goes right after the valid bytes of the final word.
  always_comb begin
    pad_word = 32'h0600_0000;
    case (bus.byte_num)
      2'd0:    pad_word = 32'h0600_0000;
      2'd1:    pad_word = {bus.in[31:24], 24'h06_0000};
      2'd2:    pad_word = {bus.in[31:16], 16'h0600};
      default: pad_word = {bus.in[31:8], 8'h06};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    block_d    = block_q;
    shift_en   = 1'b0;
    shift_word = 32'h0;
    case (state_q)
      ST_ACCEPT: begin
        if (full) begin
          if (bus.f_ack) count_d = '0;
        end else if (bus.in_ready) begin
          shift_en = 1'b1;
          if (bus.is_last) begin
            shift_word = pad_word | (last_slot ? 32'h0000_0080 : 32'h0);
            state_d    = ST_PAD;
          end else begin
            shift_word = bus.in;
          end
        end
      end
      ST_PAD: begin
        if (full) begin
          if (bus.f_ack) begin
            count_d = '0;
            state_d = ST_DONE;
          end
        end else begin
          shift_en   = 1'b1;
          shift_word = last_slot ? 32'h0000_0080 : 32'h0;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_ACCEPT;
    endcase
    if (shift_en) begin
      block_d = {block_q[BW-33:0], shift_word};
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
      count_q <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      block_q <= block_d;
    end
  end

  assign bus.out         = block_q;
  assign bus.out_ready   = full && (state_q != ST_DONE);
  assign bus.buffer_full = (state_q != ST_ACCEPT) || full;
endmodule

// File: tb/tb_pad_block_sequencer.sv
// Bench for pad_block_sequencer: directed scenarios plus random messages checked
// against a byte-level SHA-3 padding model.
module tb_pad_block_sequencer;
  localparam int RW = 18;
  localparam int BW = 32 * RW;
  localparam int RB = 4 * RW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pad_block_sequencer_if #(.RATE_WORDS(RW)) bus ();

  pad_block_sequencer #(.RATE_WORDS(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in = '0; bus.in_ready = 1'b0; bus.is_last = 1'b0; bus.byte_num = '0; bus.f_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle_after_reset(input string tag);
    checks++;
    if (bus.out !== '0) begin errors++; $display("FAIL %s out nonzero got %h", tag, bus.out); end
    checks++;
    if (bus.out_ready !== 1'b0) begin errors++; $display("FAIL %s out_ready got %b exp 0", tag, bus.out_ready); end
    checks++;
    if (bus.buffer_full !== 1'b0) begin errors++; $display("FAIL %s buffer_full got %b exp 0", tag, bus.buffer_full); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in = 32'hDEADBEEF; bus.in_ready = 1'b1; bus.is_last = 1'b1; bus.f_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle_after_reset("reset");
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_full_words();
    do_reset();
    for (int i = 1; i <= RW; i++) begin
      bus.in = 32'(i); bus.in_ready = 1'b1; bus.is_last = 1'b0;
      @(negedge clk);
      if (i == RW - 1) begin
        checks++;
        if (bus.out_ready !== 1'b0) begin errors++; $display("FAIL words17_out_ready got %b exp 0", bus.out_ready); end
      end
    end
    bus.in_ready = 1'b0;
    checks++;
    if (bus.out_ready !== 1'b1) begin errors++; $display("FAIL words_out_ready got %b exp 1", bus.out_ready); end
    checks++;
    if (bus.out[BW-1 -: 32] !== 32'h1) begin errors++; $display("FAIL words_slot0 got %h exp 00000001", bus.out[BW-1 -: 32]); end
    checks++;
    if (bus.out[31:0] !== 32'h12) begin errors++; $display("FAIL words_slot17 got %h exp 00000012", bus.out[31:0]); end
    checks++;
    if (bus.buffer_full !== 1'b1) begin errors++; $display("FAIL words_buffer_full got %b exp 1", bus.buffer_full); end
    bus.f_ack = 1'b1;
    @(negedge clk);
    bus.f_ack = 1'b0;
    checks++;
    if (bus.out_ready !== 1'b0) begin errors++; $display("FAIL words_ack_out_ready got %b exp 0", bus.out_ready); end
    checks++;
    if (bus.buffer_full !== 1'b0) begin errors++; $display("FAIL words_ack_buffer_full got %b exp 0", bus.buffer_full); end
  endtask

  task automatic test_empty_timing();
    int n;
    do_reset();
    bus.in = 32'hFFFF_FFFF; bus.in_ready = 1'b1; bus.is_last = 1'b1; bus.byte_num = 2'd0;
    @(negedge clk);
    bus.is_last = 1'b0;
    checks++;
    if (bus.out[31:0] !== 32'h0600_0000) begin errors++; $display("FAIL empty_p got %h exp 06000000", bus.out[31:0]); end
    n = 0;
    while (bus.out_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != RW - 1) begin errors++; $display("FAIL empty_latency got %0d exp %0d", n, RW - 1); end
    checks++;
    if (bus.out !== {32'h0600_0000, {(BW-64){1'b0}}, 32'h0000_0080}) begin
      errors++; $display("FAIL empty_block got %h", bus.out);
    end
    bus.in_ready = 1'b0;
    bus.f_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.f_ack = 1'b0;
    checks++;
    if (bus.out_ready !== 1'b0 || bus.buffer_full !== 1'b1) begin
      errors++; $display("FAIL empty_done got out_ready=%b buffer_full=%b exp 0/1", bus.out_ready, bus.buffer_full);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in_ready = 1'b1; bus.is_last = 1'b1; bus.byte_num = 2'd1; bus.in = 32'hAB00_0000;
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_after_reset("reset_mid_pad");
    for (int i = 0; i < RW; i++) begin
      bus.in = $urandom; bus.in_ready = 1'b1;
      @(negedge clk);
    end
    bus.in_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_after_reset("reset_wait_ack");
  endtask

  // Random message of nbytes bytes with random in_ready/f_ack activity, including
  // in_ready held while blocked and f_ack pulses with no block pending.
  task automatic run_message(input int nbytes);
    logic [7:0]  msg[$];
    logic [7:0]  pb[$];
    logic [31:0] wq[$];
    logic [31:0] w;
    logic [BW-1:0] expb;
    int nblk, nf, rem, nwords, wi, blk, cyc;
    bit checked;
    for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    pb = msg;
    pb.push_back(8'h06);
    while (pb.size() % RB != 0) pb.push_back(8'h00);
    pb[pb.size()-1] = pb[pb.size()-1] | 8'h80;
    nblk = pb.size() / RB;
    nf = nbytes / 4;
    rem = nbytes % 4;
    for (int j = 0; j < nf; j++) wq.push_back({msg[4*j], msg[4*j+1], msg[4*j+2], msg[4*j+3]});
    w = $urandom;
    for (int b = 0; b < rem; b++) w[31-8*b -: 8] = msg[4*nf+b];
    wq.push_back(w);
    nwords = wq.size();

    do_reset();
    wi = 0; blk = 0; cyc = 0; checked = 0;
    while (blk < nblk && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (bus.out_ready === 1'b1 && !checked) begin
        for (int i = 0; i < RB; i++) expb[BW-1-8*i -: 8] = pb[blk*RB+i];
        checks++;
        if (bus.out !== expb) begin
          errors++; $display("FAIL msg%0d_block%0d got %h exp %h", nbytes, blk, bus.out, expb);
        end
        checks++;
        if (bus.buffer_full !== 1'b1) begin
          errors++; $display("FAIL msg%0d_full_bf got %b exp 1", nbytes, bus.buffer_full);
        end
        checked = 1;
      end
      if (wi < nwords) begin
        bus.in_ready = ($urandom % 4) != 0;
        bus.in       = wq[wi];
        bus.is_last  = (wi == nwords - 1);
        bus.byte_num = (wi == nwords - 1) ? 2'(rem) : 2'($urandom);
      end else begin
        bus.in_ready = 1'($urandom);
        bus.in       = $urandom;
        bus.is_last  = 1'($urandom);
        bus.byte_num = 2'($urandom);
      end
      bus.f_ack = ($urandom % 3) == 0;
      if (bus.in_ready && bus.buffer_full === 1'b0 && wi < nwords) wi++;
      if (bus.f_ack && bus.out_ready === 1'b1) begin
        blk++;
        checked = 0;
      end
    end
    checks++;
    if (blk != nblk) begin errors++; $display("FAIL msg%0d_timeout got %0d blocks exp %0d", nbytes, blk, nblk); end
    bus.in_ready = 1'b1; bus.f_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_ready !== 1'b0 || bus.buffer_full !== 1'b1) begin
      errors++; $display("FAIL msg%0d_done got out_ready=%b buffer_full=%b exp 0/1", nbytes, bus.out_ready, bus.buffer_full);
    end
    idle_inputs();
  endtask

  task automatic test_random_messages();
    int lens[12] = '{0, 1, 2, 3, 4, 5, 71, 72, 73, 143, 144, 145};
    foreach (lens[i]) run_message(lens[i]);
    for (int i = 0; i < 8; i++) run_message(int'($urandom_range(0, 300)));
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_full_words();
    test_empty_timing();
    test_reset_mid();
    test_random_messages();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
